// File: rtl/shift_seq_ctrl.sv
// Sequencer for the 8-stage x 4-bit digit shift register: auto, debounced step and flush strobes,
// plus a saturating count of valid digits held.
module shift_seq_ctrl #(
  parameter int unsigned TICK_CNT = 50000000,
  parameter int unsigned DEB_CNT  = 1000000,
  parameter int unsigned DEPTH    = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       KEY_STEP,
  input  logic [1:0] SW_MODE,
  input  logic [3:0] D,
  output logic       SHIFT_EN,
  output logic [3:0] SHIFT_D,
  output logic       BUSY,
  output logic [3:0] FILL_CNT,
  output logic       LEDC
);

  localparam int unsigned TW = $clog2(TICK_CNT);
  localparam int unsigned DW = $clog2(DEB_CNT);
  localparam int unsigned FW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_HOLD, S_AUTO, S_STEP, S_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   presc_q, presc_d;
  logic            sync1_q, sync2_q;
  logic            key_acc_q, key_acc_d;
  logic [DW-1:0]   deb_q, deb_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic            flush_lock_q, flush_lock_d;
  logic            shift_en_q, shift_en_d;
  logic [3:0]      shift_d_q, shift_d_d;
  logic            busy_q, busy_d;
  logic [3:0]      fill_q, fill_d;
  logic            ledc_q, ledc_d;
  logic            step_req_c;
  logic            tick_c;
  state_t          mode_state_c;

  // Debounce: accept the synced level once it has differed for DEB_CNT cycles.
  always_comb begin
    deb_d      = '0;
    key_acc_d  = key_acc_q;
    step_req_c = 1'b0;
    if (sync2_q != key_acc_q) begin
      if (deb_q == DW'(DEB_CNT - 1)) begin
        key_acc_d  = sync2_q;
        step_req_c = ~sync2_q;
      end else begin
        deb_d = deb_q + DW'(1);
      end
    end
  end

  always_comb begin
    case (SW_MODE)
      2'b00:   mode_state_c = S_HOLD;
      2'b01:   mode_state_c = S_AUTO;
      2'b10:   mode_state_c = S_STEP;
      default: mode_state_c = S_FLUSH;
    endcase
  end

  assign tick_c = (state_q == S_AUTO) && (presc_q == TW'(TICK_CNT - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    presc_d      = '0;
    flush_cnt_d  = flush_cnt_q;
    flush_lock_d = flush_lock_q;
    shift_en_d   = 1'b0;
    shift_d_d    = 4'h0;
    busy_d       = busy_q;
    fill_d       = fill_q;
    ledc_d       = ledc_q;

    if (state_q == S_AUTO) begin
      presc_d = tick_c ? '0 : presc_q + TW'(1);
    end

    if (state_q == S_FLUSH) begin
      if (flush_cnt_q == FW'(DEPTH - 1)) begin
        state_d      = S_HOLD;
        busy_d       = 1'b0;
        fill_d       = 4'h0;
        flush_lock_d = 1'b1;
      end else begin
        flush_cnt_d = flush_cnt_q + FW'(1);
        shift_en_d  = 1'b1;
      end
    end else begin
      if (SW_MODE != 2'b11) begin
        flush_lock_d = 1'b0;
      end
      // A finished flush parks in HOLD until the switch leaves CLEAR.
      if (mode_state_c == S_FLUSH) begin
        if (!flush_lock_q) begin
          state_d     = S_FLUSH;
          busy_d      = 1'b1;
          flush_cnt_d = '0;
          shift_en_d  = 1'b1;
        end else begin
          state_d = S_HOLD;
        end
      end else begin
        state_d = mode_state_c;
      end

      if ((state_q == S_AUTO && SW_MODE == 2'b01 && tick_c) ||
          (state_q == S_STEP && SW_MODE == 2'b10 && step_req_c)) begin
        shift_en_d = 1'b1;
        shift_d_d  = D;
        if (fill_q != 4'(DEPTH)) begin
          fill_d = fill_q + 4'd1;
        end
        if (state_q == S_AUTO) begin
          ledc_d = ~ledc_q;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= S_HOLD;
      presc_q      <= '0;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      key_acc_q    <= 1'b1;
      deb_q        <= '0;
      flush_cnt_q  <= '0;
      flush_lock_q <= 1'b0;
      shift_en_q   <= 1'b0;
      shift_d_q    <= 4'h0;
      busy_q       <= 1'b0;
      fill_q       <= 4'h0;
      ledc_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      sync1_q      <= KEY_STEP;
      sync2_q      <= sync1_q;
      key_acc_q    <= key_acc_d;
      deb_q        <= deb_d;
      flush_cnt_q  <= flush_cnt_d;
      flush_lock_q <= flush_lock_d;
      shift_en_q   <= shift_en_d;
      shift_d_q    <= shift_d_d;
      busy_q       <= busy_d;
      fill_q       <= fill_d;
      ledc_q       <= ledc_d;
    end
  end

  assign SHIFT_EN = shift_en_q;
  assign SHIFT_D  = shift_d_q;
  assign BUSY     = busy_q;
  assign FILL_CNT = fill_q;
  assign LEDC     = ledc_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with TICK_CNT=4, DEB_CNT=3, DEPTH=8.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key;
  logic [1:0] sw;
  logic [3:0] d;
  logic       shift_en;
  logic [3:0] shift_d;
  logic       busy;
  logic [3:0] fill_cnt;
  logic       ledc;

  int n_tests = 0;
  int n_fail  = 0;
  int strobes;
  int toggles;
  logic       ledc_prev;
  logic [3:0] last_d;

  shift_seq_ctrl #(.TICK_CNT(4), .DEB_CNT(3), .DEPTH(8)) dut (
    .CLK(clk), .RST_N(rst_n), .KEY_STEP(key), .SW_MODE(sw), .D(d),
    .SHIFT_EN(shift_en), .SHIFT_D(shift_d), .BUSY(busy), .FILL_CNT(fill_cnt), .LEDC(ledc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles, counting strobes and remembering the last strobed digit.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      if (shift_en) begin
        strobes++;
        last_d = shift_d;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sw = 2'b01; key = 1'b1; d = 4'h5;
    strobes = 0; toggles = 0; last_d = 4'h0;

    // Reset held for two cycles while AUTO is selected.
    cyc(); chk("rst_c1", {shift_en, shift_d, busy, fill_cnt, ledc}, 0);
    cyc(); chk("rst_c2", {shift_en, shift_d, busy, fill_cnt, ledc}, 0);
    rst_n = 1'b1;
    cyc(); chk("rel_c1", {shift_en, shift_d, busy, fill_cnt, ledc}, 0);

    // AUTO: strobe every 4th cycle, first one 4 cycles after entry.
    ledc_prev = 1'b0;
    for (int i = 2; i <= 21; i++) begin
      cyc();
      chk("auto_en", shift_en, (i % 4 == 1));
      chk("auto_d", shift_d, (i % 4 == 1) ? 5 : 0);
      if (ledc != ledc_prev) toggles++;
      ledc_prev = ledc;
      if (shift_en) strobes++;
    end
    chk("auto_cnt", strobes, 5);
    chk("auto_ledc", toggles, 5);
    chk("auto_fill", fill_cnt, 5);

    // Mode change on the tick cycle suppresses the strobe.
    strobes = 0;
    run(3);
    chk("pre_tick", strobes, 0);
    sw = 2'b10;
    cyc();
    chk("tick_vs_mode", shift_en, 0);
    chk("tick_vs_fill", fill_cnt, 5);

    // STEP with a bouncing press: exactly one strobe.
    d = 4'h7; strobes = 0;
    key = 1'b0; run(1);
    key = 1'b1; run(1);
    key = 1'b0; run(10);
    key = 1'b1; run(6);
    chk("deb_cnt", strobes, 1);
    chk("deb_d", last_d, 7);
    chk("deb_fill", fill_cnt, 6);

    // Single-cycle glitch is rejected.
    strobes = 0;
    key = 1'b0; run(1);
    key = 1'b1; run(8);
    chk("glitch", strobes, 0);

    // Ten presses carrying 1..A; fill saturates at 8.
    for (int i = 1; i <= 10; i++) begin
      d = 4'(i); strobes = 0;
      key = 1'b0; run(6);
      key = 1'b1; run(6);
      chk("sat_cnt", strobes, 1);
      chk("sat_d", last_d, i);
      chk("sat_fill", fill_cnt, (6 + i > 8) ? 8 : 6 + i);
    end

    // Flush: 8 zero strobes under BUSY, switch wiggle ignored.
    d = 4'h9; sw = 2'b11;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("fl_busy", busy, 1);
      chk("fl_en", shift_en, 1);
      chk("fl_d", shift_d, 0);
      if (k == 2) sw = 2'b01;
      if (k == 5) sw = 2'b11;
    end
    cyc();
    chk("fl_end", {shift_en, busy}, 0);
    chk("fl_fill", fill_cnt, 0);
    strobes = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("fl_park", {shift_en, busy}, 0);
    end

    // Leaving CLEAR re-enables AUTO normally.
    sw = 2'b01;
    cyc();
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("post_auto_wait", shift_en, 0);
    end
    cyc();
    chk("post_auto_en", shift_en, 1);
    chk("post_auto_d", shift_d, 9);
    chk("post_auto_fill", fill_cnt, 1);

    // Reset on the third flush strobe aborts the flush.
    sw = 2'b11;
    cyc(); cyc(); cyc();
    chk("rf_3rd", {shift_en, busy}, 2'b11);
    chk("rf_fill", fill_cnt, 1);
    rst_n = 1'b0;
    cyc();
    chk("rf_abort", {shift_en, shift_d, busy, fill_cnt, ledc}, 0);
    rst_n = 1'b1; sw = 2'b00; strobes = 0;
    run(4);
    chk("rf_quiet", strobes, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
